// File: rtl/mprjram_arb_pkg.sv
`default_nettype none
// mprjram_arb_pkg: shared types and constants for the BRAM arbiter.
package mprjram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic {
    REQ_WB = 1'b0,
    REQ_UX = 1'b1
  } req_id_t;

  localparam logic [7:0] WB_REGION = 8'h38;
  localparam int         CNT_W     = $clog2(256);

endpackage
`default_nettype wire

// File: rtl/mprjram_arbiter_if.sv
`default_nettype none
// mprjram_arbiter_if: Wishbone slave, UART-buffer requester and BRAM port bundle.
interface mprjram_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;

  logic              ux_req_i;
  logic              ux_we_i;
  logic [ADDR_W-1:0] ux_adr_i;
  logic [31:0]       ux_dat_i;
  logic              ux_gnt_o;
  logic              ux_done_o;
  logic [31:0]       ux_dat_o;

  logic              bram_en_o;
  logic [3:0]        bram_we_o;
  logic [ADDR_W-1:0] bram_adr_o;
  logic [31:0]       bram_di_o;
  logic [31:0]       bram_do_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  ux_req_i, ux_we_i, ux_adr_i, ux_dat_i,
    output ux_gnt_o, ux_done_o, ux_dat_o,
    output bram_en_o, bram_we_o, bram_adr_o, bram_di_o,
    input  bram_do_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output ux_req_i, ux_we_i, ux_adr_i, ux_dat_i,
    input  ux_gnt_o, ux_done_o, ux_dat_o,
    input  bram_en_o, bram_we_o, bram_adr_o, bram_di_o,
    output bram_do_i
  );
endinterface
`default_nettype wire

// File: rtl/arb_delay_cnt.sv
`default_nettype none
// arb_delay_cnt: loadable down-counter timing the BRAM access latency.
module arb_delay_cnt
  import mprjram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Flags the decrement that empties the counter, so the waiter leaves on that same cycle.
  assign zero = (count <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/mprjram_arbiter.sv
`default_nettype none
// mprjram_arbiter: shares one BRAM port between the Wishbone slave and the UART buffer.
// Define ARB_ROUND_ROBIN_EN to alternate tied grants; otherwise Wishbone always wins a tie.
module mprjram_arbiter
  import mprjram_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DELAYS = 10
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  mprjram_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DELAYS - 1);

  state_t            state, state_d;
  req_id_t           owner, owner_d, pick;
  logic              is_wr, is_wr_d;
  logic              wb_abort, wb_abort_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              wb_req, ux_req;

  logic              bram_en_q, bram_en_d;
  logic [3:0]        bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_adr_q, bram_adr_d;
  logic [31:0]       bram_di_q, bram_di_d;
  logic              wbs_ack_q, wbs_ack_d;
  logic [31:0]       wbs_dat_q, wbs_dat_d;
  logic              ux_gnt_q, ux_gnt_d;
  logic              ux_done_q, ux_done_d;
  logic [31:0]       ux_dat_q, ux_dat_d;
`ifdef ARB_ROUND_ROBIN_EN
  req_id_t           last_gnt, last_gnt_d;
`endif

  logic unused_adr;
  assign unused_adr = ^{bus.wbs_adr_i[23:ADDR_W+2], bus.wbs_adr_i[1:0]};

  assign wb_req = bus.wbs_cyc_i & bus.wbs_stb_i & (bus.wbs_adr_i[31:24] == WB_REGION);
  assign ux_req = bus.ux_req_i;

  arb_delay_cnt u_delay_cnt (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (LOAD_VAL),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state;
    owner_d    = owner;
    is_wr_d    = is_wr;
    wb_abort_d = wb_abort;
    pick       = REQ_WB;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    bram_en_d  = 1'b0;
    bram_we_d  = 4'h0;
    bram_adr_d = bram_adr_q;
    bram_di_d  = bram_di_q;
    wbs_ack_d  = 1'b0;
    wbs_dat_d  = wbs_dat_q;
    ux_done_d  = 1'b0;
    ux_dat_d   = ux_dat_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_d = last_gnt;
`endif

    case (state)
      ST_IDLE: begin
        if (wb_req || ux_req) begin
          if (wb_req && ux_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = (last_gnt == REQ_WB) ? REQ_UX : REQ_WB;
`else
            pick = REQ_WB;
`endif
          end else begin
            pick = ux_req ? REQ_UX : REQ_WB;
          end
          state_d    = ST_ACCESS;
          owner_d    = pick;
          wb_abort_d = 1'b0;
          bram_en_d  = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_gnt_d = pick;
`endif
          if (pick == REQ_UX) begin
            is_wr_d    = bus.ux_we_i;
            bram_we_d  = bus.ux_we_i ? 4'hF : 4'h0;
            bram_adr_d = bus.ux_adr_i;
            bram_di_d  = bus.ux_dat_i;
          end else begin
            is_wr_d    = bus.wbs_we_i;
            bram_we_d  = bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
            bram_adr_d = bus.wbs_adr_i[ADDR_W+1:2];
            bram_di_d  = bus.wbs_dat_i;
          end
        end
      end
      ST_ACCESS: begin
        cnt_load = 1'b1;
        state_d  = (DELAYS > 1) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase

    // A Wishbone master that lets go of the cycle forfeits its ack; the access itself still runs out.
    if ((state != ST_IDLE) && (owner == REQ_WB) && !bus.wbs_cyc_i) wb_abort_d = 1'b1;

    if (state_d == ST_RESP) begin
      if (owner == REQ_UX) begin
        ux_done_d = 1'b1;
        if (!is_wr) ux_dat_d = bus.bram_do_i;
      end else begin
        wbs_ack_d = !wb_abort_d;
        if (!is_wr) wbs_dat_d = bus.bram_do_i;
      end
    end

    ux_gnt_d = (state_d != ST_IDLE) && (owner_d == REQ_UX);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= ST_IDLE;
      owner      <= REQ_WB;
      is_wr      <= 1'b0;
      wb_abort   <= 1'b0;
      bram_en_q  <= 1'b0;
      bram_we_q  <= 4'h0;
      bram_adr_q <= '0;
      bram_di_q  <= '0;
      wbs_ack_q  <= 1'b0;
      wbs_dat_q  <= '0;
      ux_gnt_q   <= 1'b0;
      ux_done_q  <= 1'b0;
      ux_dat_q   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      is_wr      <= is_wr_d;
      wb_abort   <= wb_abort_d;
      bram_en_q  <= bram_en_d;
      bram_we_q  <= bram_we_d;
      bram_adr_q <= bram_adr_d;
      bram_di_q  <= bram_di_d;
      wbs_ack_q  <= wbs_ack_d;
      wbs_dat_q  <= wbs_dat_d;
      ux_gnt_q   <= ux_gnt_d;
      ux_done_q  <= ux_done_d;
      ux_dat_q   <= ux_dat_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) last_gnt <= REQ_UX;
    else           last_gnt <= last_gnt_d;
  end
`endif

  assign bus.bram_en_o  = bram_en_q;
  assign bus.bram_we_o  = bram_we_q;
  assign bus.bram_adr_o = bram_adr_q;
  assign bus.bram_di_o  = bram_di_q;
  assign bus.wbs_ack_o  = wbs_ack_q;
  assign bus.wbs_dat_o  = wbs_dat_q;
  assign bus.ux_gnt_o   = ux_gnt_q;
  assign bus.ux_done_o  = ux_done_q;
  assign bus.ux_dat_o   = ux_dat_q;

endmodule
`default_nettype wire

// File: doc/mprjram_arbiter.md
MPRJRAM_ARBITER -- requirements
Module: mprjram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, BRAM word-address width.
REQ-002 SHALL have parameter DELAYS, default 10, BRAM access latency in cycles, legal range 1..255.
REQ-003 SHALL have port wb_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave controls.
REQ-006 SHALL have ports wbs_sel_i in 4, wbs_adr_i in 32, wbs_dat_i in 32  Wishbone byte select, address, write data.
REQ-007 SHALL have ports wbs_ack_o out 1, wbs_dat_o out 32  Wishbone ack and read data.
REQ-008 SHALL have ports ux_req_i in 1, ux_we_i in 1, ux_adr_i in ADDR_W, ux_dat_i in 32  second requester (UART buffer): request, write, word address, write data.
REQ-009 SHALL have ports ux_gnt_o out 1, ux_done_o out 1, ux_dat_o out 32  grant, completion pulse, read data.
REQ-010 SHALL have ports bram_en_o out 1, bram_we_o out 4, bram_adr_o out ADDR_W, bram_di_o out 32, bram_do_i in 32  shared BRAM port.

Function
REQ-011 WB request valid only when wbs_cyc_i & wbs_stb_i & wbs_adr_i[31:24]==8'h38; WB word address = wbs_adr_i[ADDR_W+1:2].
REQ-012 FSM states IDLE, ACCESS, WAIT, RESP; IDLE with any valid request -> ACCESS, registering the granted requester.
REQ-013 ACCESS: bram_en_o=1 for exactly one cycle with granted address/data; counter loaded DELAYS-1; -> WAIT if DELAYS>1, else -> RESP.
REQ-014 WAIT: counter decrements each cycle; at zero -> RESP.
REQ-015 RESP: bram_do_i captured into wbs_dat_o or ux_dat_o; one-cycle wbs_ack_o or ux_done_o pulse; -> IDLE.
REQ-016 Latency: request seen in IDLE at cycle 0 -> completion pulse in cycle DELAYS+1; identical for reads and writes.
REQ-017 bram_we_o = wbs_sel_i on WB write, 4'hF on ux write, 4'h0 on reads; bram_di_o from granted requester.
REQ-018 ux_gnt_o high from ACCESS through RESP of a ux transaction; ux_req_i held by requester until ux_done_o.
REQ-019 wbs_cyc_i low at any point after grant: BRAM access completes, wbs_ack_o suppressed, return to IDLE normally.
REQ-020 Both requests valid in same IDLE cycle: arbitration per REQ-024; loser stays pending, served on next IDLE.
REQ-021 All outputs registered; wbs_dat_o/ux_dat_o hold last read value until next read RESP of that requester.

Reset
REQ-022 wb_rst_n low asynchronously forces state IDLE, counter 0, last-grant = ux, all outputs 0.
REQ-023 Reset mid-transaction abandons it: no ack/done pulse issued after release.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN defined: tie goes to requester not granted last (first tie after reset -> WB); undefined: tie always goes to WB, last-grant register omitted.

Structure
REQ-025 Package mprjram_arb_pkg SHALL hold the state enum, the 8'h38 region constant, and requester-id typedef.
REQ-026 Latency counter SHALL be sub-module arb_delay_cnt (load, decrement, zero flag, width $clog2(256)).

Verification
REQ-027 DELAYS=10, WB read 0x38000010, bram_do_i=0x0000003E -> bram_adr_o=4, single bram_en_o pulse, wbs_ack_o one cycle 11 cycles after stb, wbs_dat_o=0x3E.
REQ-028 WB write 0x38000020, sel 4'b0011, data 0x12345678 -> bram_we_o=4'b0011, bram_adr_o=8, bram_di_o=0x12345678, ack at cycle 11.
REQ-029 Last grant WB, then WB and ux both valid in same IDLE cycle -> with ARB_ROUND_ROBIN_EN ux_gnt_o first; without, WB first, ux after.
REQ-030 WB read 0x30000000 -> no bram_en_o, no wbs_ack_o within 30 cycles; ux request then served normally.
REQ-031 wb_rst_n low during WAIT -> all outputs 0 immediately, no ack after release; following read completes at cycle DELAYS+1.
REQ-032 wbs_cyc_i dropped in WAIT -> no wbs_ack_o; pending ux write 0x55 addr 3 completes with ux_done_o DELAYS+1 cycles after its IDLE.
